// File: rtl/costas_loop_filter.sv
// Costas loop back end: box-car decimating LPF on I/Q, sign(I)*Q phase detector,
// PI loop filter and lock detector producing one DDS tuning word per window.
module costas_loop_filter #(
  parameter int                   DATA_WIDTH  = 16,
  parameter int                   DEC_LOG2    = 6,
  parameter int                   FTW_WIDTH   = 32,
  parameter logic [FTW_WIDTH-1:0] FTW_CENTER  = 32'h0CCC_CCCD,
  parameter int                   KP_SHIFT    = 12,
  parameter int                   KI_SHIFT    = 4,
  parameter int                   LOCK_THRESH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loop_en,
  input  logic [15:0]           S_AXIS_I_tdata,
  input  logic                  S_AXIS_I_tvalid,
  input  logic [15:0]           S_AXIS_Q_tdata,
  input  logic                  S_AXIS_Q_tvalid,
  output logic [FTW_WIDTH-1:0]  M_AXIS_FTW_tdata,
  output logic                  M_AXIS_FTW_tvalid,
  output logic                  locked,
  output logic [DATA_WIDTH-1:0] debug_I_lpf,
  output logic [DATA_WIDTH-1:0] debug_Q_lpf,
  output logic [DATA_WIDTH-1:0] debug_err
);

  localparam int AW = DATA_WIDTH + DEC_LOG2;
  localparam logic [DEC_LOG2-1:0]   CNT_LAST = {DEC_LOG2{1'b1}};
  localparam logic [DATA_WIDTH:0]   LOCK_T   = LOCK_THRESH[DATA_WIDTH:0];
  localparam logic [4:0]            LOCK_MAX = 5'd16;
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [FTW_WIDTH-1:0]  F_MIN = {1'b1, {(FTW_WIDTH-1){1'b0}}};
  localparam logic signed [FTW_WIDTH-1:0]  F_MAX = {1'b0, {(FTW_WIDTH-1){1'b1}}};

  logic signed [AW-1:0]         acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [DEC_LOG2-1:0]          cnt_q, cnt_d;
  logic                         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, tv_q, tv_d;
  logic signed [DATA_WIDTH-1:0] i_lpf_q, i_lpf_d, q_lpf_q, q_lpf_d, err_q, err_d;
  logic signed [FTW_WIDTH-1:0]  integ_q, integ_d, prop_q, prop_d;
  logic [FTW_WIDTH-1:0]         ftw_q, ftw_d;
  logic [4:0]                   lock_cnt_q, lock_cnt_d;
  logic                         locked_q, locked_d;

  logic                         accept_s;
  logic signed [DATA_WIDTH-1:0] x_i_s, x_q_s, neg_q_s, err_new_s;
  logic signed [AW-1:0]         sum_i_s, sum_q_s;
  logic signed [DATA_WIDTH:0]   err_wide_s;
  logic [DATA_WIDTH:0]          err_abs_s;
  logic signed [FTW_WIDTH-1:0]  err_ext_s, prop_new_s, ki_term_s, integ_sat_s;
  logic signed [FTW_WIDTH:0]    integ_sum_s;

  assign accept_s = S_AXIS_I_tvalid & S_AXIS_Q_tvalid;
  assign x_i_s    = S_AXIS_I_tdata[DATA_WIDTH-1:0];
  assign x_q_s    = S_AXIS_Q_tdata[DATA_WIDTH-1:0];
  assign sum_i_s  = acc_i_q + {{DEC_LOG2{x_i_s[DATA_WIDTH-1]}}, x_i_s};
  assign sum_q_s  = acc_q_q + {{DEC_LOG2{x_q_s[DATA_WIDTH-1]}}, x_q_s};

  // Negating the most negative value would overflow, so it clamps to the max.
  assign neg_q_s    = (q_lpf_q == D_MIN) ? D_MAX : -q_lpf_q;
  assign err_new_s  = i_lpf_q[DATA_WIDTH-1] ? neg_q_s : q_lpf_q;
  assign err_wide_s = {err_new_s[DATA_WIDTH-1], err_new_s};
  assign err_abs_s  = err_wide_s[DATA_WIDTH] ? $unsigned(-err_wide_s) : $unsigned(err_wide_s);

  assign err_ext_s   = {{(FTW_WIDTH-DATA_WIDTH){err_q[DATA_WIDTH-1]}}, err_q};
  assign prop_new_s  = err_ext_s <<< KP_SHIFT;
  assign ki_term_s   = err_ext_s <<< KI_SHIFT;
  assign integ_sum_s = {integ_q[FTW_WIDTH-1], integ_q} + {ki_term_s[FTW_WIDTH-1], ki_term_s};
  assign integ_sat_s = (integ_sum_s[FTW_WIDTH] == integ_sum_s[FTW_WIDTH-1]) ? integ_sum_s[FTW_WIDTH-1:0]
                     : (integ_sum_s[FTW_WIDTH] ? F_MIN : F_MAX);

  // Next-state logic for the accumulators, the update pipeline and the lock detector.
  always_comb begin
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    i_lpf_d    = i_lpf_q;
    q_lpf_d    = q_lpf_q;
    err_d      = err_q;
    integ_d    = integ_q;
    prop_d     = prop_q;
    ftw_d      = ftw_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    s1_d       = 1'b0;
    s2_d       = s1_q;
    s3_d       = s2_q;
    tv_d       = s3_q;

    if (accept_s) begin
      if (cnt_q == CNT_LAST) begin
        i_lpf_d = sum_i_s[AW-1:DEC_LOG2];
        q_lpf_d = sum_q_s[AW-1:DEC_LOG2];
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
        s1_d    = 1'b1;
      end else begin
        acc_i_d = sum_i_s;
        acc_q_d = sum_q_s;
        cnt_d   = cnt_q + {{(DEC_LOG2-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (s1_q) begin
      err_d = err_new_s;
      if (err_abs_s < LOCK_T) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 5'd1;
      end else begin
        lock_cnt_d = 5'd0;
      end
      locked_d = (lock_cnt_d == LOCK_MAX);
    end else begin
      err_d = err_q;
    end

    if (s2_q) begin
      if (loop_en) begin
        integ_d = integ_sat_s;
        prop_d  = prop_new_s;
      end else begin
        integ_d = '0;
        prop_d  = '0;
      end
    end else begin
      integ_d = integ_q;
    end

    if (s3_q) begin
      ftw_d = FTW_CENTER + $unsigned(integ_q) + $unsigned(prop_q);
    end else begin
      ftw_d = ftw_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      cnt_q      <= '0;
      i_lpf_q    <= '0;
      q_lpf_q    <= '0;
      err_q      <= '0;
      integ_q    <= '0;
      prop_q     <= '0;
      ftw_q      <= FTW_CENTER;
      lock_cnt_q <= 5'd0;
      locked_q   <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      tv_q       <= 1'b0;
    end else begin
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      i_lpf_q    <= i_lpf_d;
      q_lpf_q    <= q_lpf_d;
      err_q      <= err_d;
      integ_q    <= integ_d;
      prop_q     <= prop_d;
      ftw_q      <= ftw_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      tv_q       <= tv_d;
    end
  end

  assign M_AXIS_FTW_tdata  = ftw_q;
  assign M_AXIS_FTW_tvalid = tv_q;
  assign locked            = locked_q;
  assign debug_I_lpf       = i_lpf_q;
  assign debug_Q_lpf       = q_lpf_q;
  assign debug_err         = err_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Scoreboard bench: a window-level reference model pushes expected updates, a
// negedge monitor pops them on every tvalid pulse. A second instance with a
// large integral gain exercises integrator saturation in few windows.
module tb_costas_loop_filter;
  localparam logic [31:0] CENTER = 32'h0CCC_CCCD;

  logic        clk = 1'b0;
  logic        rst, loop_en, i_valid, q_valid;
  logic [15:0] i_data, q_data;
  logic [31:0] ftw, ftw_hi;
  logic        tv, tv_hi, lck, lck_hi;
  logic [15:0] dbg_i, dbg_q, dbg_err, dbg_i_hi, dbg_q_hi, dbg_err_hi;

  always #5 clk = ~clk;

  costas_loop_filter dut (
    .clk(clk), .rst(rst), .loop_en(loop_en),
    .S_AXIS_I_tdata(i_data), .S_AXIS_I_tvalid(i_valid),
    .S_AXIS_Q_tdata(q_data), .S_AXIS_Q_tvalid(q_valid),
    .M_AXIS_FTW_tdata(ftw), .M_AXIS_FTW_tvalid(tv), .locked(lck),
    .debug_I_lpf(dbg_i), .debug_Q_lpf(dbg_q), .debug_err(dbg_err)
  );

  costas_loop_filter #(.KI_SHIFT(14)) u_hi (
    .clk(clk), .rst(rst), .loop_en(loop_en),
    .S_AXIS_I_tdata(i_data), .S_AXIS_I_tvalid(i_valid),
    .S_AXIS_Q_tdata(q_data), .S_AXIS_Q_tvalid(q_valid),
    .M_AXIS_FTW_tdata(ftw_hi), .M_AXIS_FTW_tvalid(tv_hi), .locked(lck_hi),
    .debug_I_lpf(dbg_i_hi), .debug_Q_lpf(dbg_q_hi), .debug_err(dbg_err_hi)
  );

  typedef struct {
    logic [31:0] ftw;
    logic [31:0] ftw_hi;
    int          ilpf;
    int          qlpf;
    int          err;
    bit          locked;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     m_cnt, m_lock;
  longint m_sum_i, m_sum_q, m_integ, m_integ_hi;

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic longint clamp32(longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    else if (v < -64'sd2147483648) return -64'sd2147483648;
    else return v;
  endfunction

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  function automatic int rnd(int noise);
    if (noise == 0) return 0;
    return int'($urandom_range(2 * noise)) - noise;
  endfunction

  // Reference model: average a window, derive error, run the PI filter arithmetically.
  task automatic model_sample(int xi, int xq);
    exp_t   e;
    int     ai, aq, er;
    longint prop;
    m_sum_i += xi;
    m_sum_q += xq;
    if (m_cnt == 63) begin
      ai = int'(m_sum_i >>> 6);
      aq = int'(m_sum_q >>> 6);
      if (ai >= 0) er = aq;
      else if (aq == -32768) er = 32767;
      else er = -aq;
      if (er < 1024 && er > -1024) m_lock = (m_lock == 16) ? 16 : m_lock + 1;
      else m_lock = 0;
      if (loop_en) begin
        m_integ    = clamp32(m_integ + longint'(er) * 16);
        m_integ_hi = clamp32(m_integ_hi + longint'(er) * 16384);
        prop       = longint'(er) * 4096;
      end else begin
        m_integ = 0; m_integ_hi = 0; prop = 0;
      end
      e.ftw    = 32'(longint'(CENTER) + m_integ + prop);
      e.ftw_hi = 32'(longint'(CENTER) + m_integ_hi + prop);
      e.ilpf   = ai;
      e.qlpf   = aq;
      e.err    = er;
      e.locked = (m_lock == 16);
      exp_q.push_back(e);
      m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic pair(int xi, int xq);
    @(posedge clk); #1;
    i_data = 16'(xi); q_data = 16'(xq); i_valid = 1'b1; q_valid = 1'b1;
    model_sample(xi, xq);
  endtask

  task automatic gap(int kind);
    @(posedge clk); #1;
    i_data = 16'd5000; q_data = 16'(kind == 2 ? 5000 : int'($urandom));
    i_valid = (kind == 1); q_valid = (kind == 2);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0; q_valid = 1'b0;
    end
  endtask

  task automatic window(int ci, int cq, int noise, int gap_pct);
    for (int n = 0; n < 64; n++) begin
      if (int'($urandom_range(99)) < gap_pct) gap(int'($urandom_range(2)));
      pair(sat16(ci + rnd(noise)), sat16(cq + rnd(noise)));
    end
    idle(6);
  endtask

  // Asserts reset away from the clock edge and checks the outputs react at once.
  task automatic do_reset();
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("rst_ftw", ftw, CENTER);
    check("rst_tvalid", tv, 0);
    check("rst_locked", lck, 0);
    check("rst_dbg_i", dbg_i, 0);
    check("rst_dbg_q", dbg_q, 0);
    check("rst_dbg_err", dbg_err, 0);
    m_cnt = 0; m_sum_i = 0; m_sum_q = 0; m_integ = 0; m_integ_hi = 0; m_lock = 0;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: every tvalid pulse must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tv) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_tvalid: got a pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        check("ftw", ftw, e.ftw);
        check("ftw_hi_gain", ftw_hi, e.ftw_hi);
        check("i_lpf", $signed(dbg_i), e.ilpf);
        check("q_lpf", $signed(dbg_q), e.qlpf);
        check("err", $signed(dbg_err), e.err);
        check("locked", lck, e.locked);
      end
    end
  end

  initial begin
    int lat;
    rst = 1'b1; loop_en = 1'b1; i_valid = 1'b0; q_valid = 1'b0;
    i_data = 16'd0; q_data = 16'd0;
    m_cnt = 0; m_sum_i = 0; m_sum_q = 0; m_integ = 0; m_integ_hi = 0; m_lock = 0;
    #1;
    check("init_ftw", ftw, CENTER);
    check("init_tvalid", tv, 0);
    check("init_locked", lck, 0);
    idle(3);
    rst = 1'b0;

    // Positive error, two identical windows; measure dump-to-pulse latency on the second.
    window(1000, 200, 0, 0);
    for (int n = 0; n < 64; n++) pair(1000, 200);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      i_valid = 1'b0; q_valid = 1'b0;
      lat++;
      if (tv) break;
    end
    check("latency_edges", lat, 4);
    idle(4);

    // Negative error and negation saturation.
    window(-1000, 200, 0, 0);
    window(-1, -32768, 0, 0);

    // Unpaired valids must not disturb the average.
    window(300, -700, 20, 50);

    // Partial window discarded by reset, pulse cancelled by reset.
    for (int n = 0; n < 30; n++) pair(4000, 4000);
    do_reset();
    window(-500, 900, 50, 10);
    for (int n = 0; n < 64; n++) pair(1200, 3000);
    do_reset();

    // Integrator saturation in the high-gain instance.
    for (int w = 0; w < 8; w++) window(-1, -32768, 0, 0);
    for (int w = 0; w < 4; w++) window(100, -32768, 0, 0);

    // Open loop: every pulse must be the centre word.
    loop_en = 1'b0;
    for (int w = 0; w < 3; w++)
      window(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, 100, 20);
    loop_en = 1'b1;

    // Lock detector: one bad window, 16 good ones, then one bad one.
    window(1000, 2000, 0, 0);
    for (int w = 0; w < 16; w++) window(200, 100, 0, 5);
    window(1000, 2000, 0, 0);

    // Randomized windows.
    for (int w = 0; w < 15; w++) begin
      loop_en = ($urandom_range(9) != 0);
      window(int'($urandom_range(65535)) - 32768, int'($urandom_range(3000)) - 1500,
             int'($urandom_range(400)), int'($urandom_range(40)));
    end

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
    check("pending_updates", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
